// File: rtl/trace_p2b_pkg.sv
// Shared constants, FSM encoding and helpers for the trace packet-to-byte serialiser.
package trace_p2b_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHAN     = 3'd1,
        CHAN_B   = 3'd2,
        SOP      = 3'd3,
        EOP      = 3'd4,
        DATA_ESC = 3'd5,
        DATA     = 3'd6
    } p2b_state_t;

    // True when a byte collides with one of the in-band control characters.
    function automatic logic is_ctrl_char(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

    // First state after the channel marker has been dealt with.
    function automatic p2b_state_t after_chan(input logic sop, input logic eop, input logic data_esc);
        if (sop) begin
            return SOP;
        end else if (eop) begin
            return EOP;
        end else if (data_esc) begin
            return DATA_ESC;
        end
        return DATA;
    endfunction

endpackage

// File: rtl/trace_p2b_escape.sv
// Escape classifier: flags control-character collisions and produces the XORed substitute byte.
module trace_p2b_escape
    import trace_p2b_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic       need_esc,
    output logic [7:0] esc_byte
);

    assign need_esc = is_ctrl_char(in_byte);
    assign esc_byte = in_byte ^ ESC_XOR;

endmodule

// File: rtl/trace_packets_to_bytes.sv
// Serialises an Avalon-ST packet stream into an escaped byte stream with in-band SOP/EOP/CHAN markers.
// Build option: TRACE_P2B_CHAN_ALWAYS_EN forces a channel marker on every sop beat.
module trace_packets_to_bytes
    import trace_p2b_pkg::*;
#(
    parameter int unsigned CHANNEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic [CHANNEL_W-1:0] in_channel,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data
);

    p2b_state_t           state_q, state_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic [CHANNEL_W-1:0] hold_chan_q, hold_chan_d;
    logic                 hold_sop_q, hold_sop_d;
    logic                 hold_eop_q, hold_eop_d;
    logic                 chan_esc_done_q, chan_esc_done_d;
    logic [CHANNEL_W-1:0] last_chan_q, last_chan_d;
    logic                 last_chan_vld_q, last_chan_vld_d;

    logic       data_need_esc, chan_need_esc;
    logic [7:0] data_esc_byte, chan_esc_byte, chan_byte;
    logic       fire, load, need_chan_in;
    p2b_state_t first_st;

    assign chan_byte = 8'(hold_chan_q);

    trace_p2b_escape u_data_esc (
        .in_byte  (hold_data_q),
        .need_esc (data_need_esc),
        .esc_byte (data_esc_byte)
    );

    trace_p2b_escape u_chan_esc (
        .in_byte  (chan_byte),
        .need_esc (chan_need_esc),
        .esc_byte (chan_esc_byte)
    );

    // Next-state, holding-register and output decode.
    always_comb begin
        state_d         = state_q;
        hold_vld_d      = hold_vld_q;
        hold_data_d     = hold_data_q;
        hold_chan_d     = hold_chan_q;
        hold_sop_d      = hold_sop_q;
        hold_eop_d      = hold_eop_q;
        chan_esc_done_d = chan_esc_done_q;
        last_chan_d     = last_chan_q;
        last_chan_vld_d = last_chan_vld_q;
        out_data        = 8'h00;

        in_ready  = !reset && (!hold_vld_q || ((state_q == DATA) && out_ready));
        out_valid = hold_vld_q;
        fire      = hold_vld_q && out_ready;
        load      = in_valid && in_ready;

`ifdef TRACE_P2B_CHAN_ALWAYS_EN
        need_chan_in = (in_channel != last_chan_q) || !last_chan_vld_q || in_startofpacket;
`else
        need_chan_in = (in_channel != last_chan_q) || !last_chan_vld_q;
`endif
        first_st = need_chan_in ? CHAN
                                : after_chan(in_startofpacket, in_endofpacket, is_ctrl_char(in_data));

        case (state_q)
            IDLE: begin
                out_data = 8'h00;
            end
            CHAN: begin
                out_data = CHAN_CHAR;
                if (fire) begin
                    state_d         = CHAN_B;
                    chan_esc_done_d = 1'b0;
                end
            end
            CHAN_B: begin
                // Two-byte escape sequence for a colliding channel byte stays in this state.
                if (chan_need_esc && !chan_esc_done_q) begin
                    out_data = ESC_CHAR;
                    if (fire) begin
                        chan_esc_done_d = 1'b1;
                    end
                end else begin
                    out_data = chan_need_esc ? chan_esc_byte : chan_byte;
                    if (fire) begin
                        state_d         = after_chan(hold_sop_q, hold_eop_q, data_need_esc);
                        last_chan_d     = hold_chan_q;
                        last_chan_vld_d = 1'b1;
                        chan_esc_done_d = 1'b0;
                    end
                end
            end
            SOP: begin
                out_data = SOP_CHAR;
                if (fire) begin
                    state_d = after_chan(1'b0, hold_eop_q, data_need_esc);
                end
            end
            EOP: begin
                out_data = EOP_CHAR;
                if (fire) begin
                    state_d = after_chan(1'b0, 1'b0, data_need_esc);
                end
            end
            DATA_ESC: begin
                out_data = ESC_CHAR;
                if (fire) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                out_data = data_need_esc ? data_esc_byte : hold_data_q;
                if (fire) begin
                    state_d    = IDLE;
                    hold_vld_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_vld_d = 1'b0;
            end
        endcase

        if (load) begin
            hold_vld_d      = 1'b1;
            hold_data_d     = in_data;
            hold_chan_d     = in_channel;
            hold_sop_d      = in_startofpacket;
            hold_eop_d      = in_endofpacket;
            chan_esc_done_d = 1'b0;
            state_d         = first_st;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_vld_q      <= 1'b0;
            hold_data_q     <= 8'h00;
            hold_chan_q     <= '0;
            hold_sop_q      <= 1'b0;
            hold_eop_q      <= 1'b0;
            chan_esc_done_q <= 1'b0;
            last_chan_q     <= '0;
            last_chan_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_vld_q      <= hold_vld_d;
            hold_data_q     <= hold_data_d;
            hold_chan_q     <= hold_chan_d;
            hold_sop_q      <= hold_sop_d;
            hold_eop_q      <= hold_eop_d;
            chan_esc_done_q <= chan_esc_done_d;
            last_chan_q     <= last_chan_d;
            last_chan_vld_q <= last_chan_vld_d;
        end
    end

endmodule
